// File: rtl/FIR_pkg.sv
// Shared types and helpers for the hierarchical FIR adder.
// Holds the sequencer state encoding and output saturation.
package FIR_pkg;

   localparam int FIR_K                 = 128;
   localparam int FIR_N                 = 8;
   localparam int FIR_WIDTH_COEFFICIENT = 32;
   localparam int FIR_MCA_NUM_ADDITIONS = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } seq_state_e;

   // Clamp a signed value into the signed range of a w-bit word.
   function automatic logic signed [63:0] sat_to_width(
      input logic signed [63:0] v,
      input int unsigned        w
   );
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/mca_sat_acc.sv
// Clearable signed accumulator for chunk partial sums.
// sum_sat shows the saturated total including this cycle's addend.
module mca_sat_acc
   import FIR_pkg::*;
#(
   parameter int W     = 32,
   parameter int ACC_W = 36
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                clr,
   input  logic                add_en,
   input  logic signed [W-1:0] din,
   output logic signed [W-1:0] sum_sat
);

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_nxt;

   // Running total plus the addend being accepted this cycle.
   always_comb begin
      acc_nxt = acc;
      if (add_en) acc_nxt = acc + ACC_W'(din);
      sum_sat = W'(sat_to_width(64'(acc_nxt), W));
   end

   // Clear wins so a new computation can start while the old one closes.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) acc <= '0;
      else if (clr) acc <= '0;
      else acc <= acc_nxt;
   end

endmodule

// File: rtl/mca_sequencer.sv
// Chunk sequencer for the multi-cycle hierarchical FIR adder.
// Issues chunks, accumulates results, publishes saturated samples.
module mca_sequencer
   import FIR_pkg::*;
#(
   parameter  int K                 = FIR_K,
   parameter  int N                 = FIR_N,
   parameter  int WIDTH_COEFFICIENT = FIR_WIDTH_COEFFICIENT,
   parameter  int MCA_NUM_ADDITIONS = FIR_MCA_NUM_ADDITIONS,
   localparam int NUM_CHUNKS =
      (K + MCA_NUM_ADDITIONS - 1) / MCA_NUM_ADDITIONS + 0 * N,
   localparam int CW    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1,
   localparam int LW    = $clog2(MCA_NUM_ADDITIONS) + 1,
   localparam int ACC_W = WIDTH_COEFFICIENT + $clog2(NUM_CHUNKS) + 1
) (
   input  logic                                clk,
   input  logic                                resetn,
   input  logic                                start,
   output logic [CW-1:0]                       chunk_idx,
   output logic [LW-1:0]                       chunk_len,
   output logic                                chunk_valid,
   input  logic signed [WIDTH_COEFFICIENT-1:0] partial_sum,
   output logic                                busy,
   output logic signed [WIDTH_COEFFICIENT-1:0] sample,
   output logic                                sample_valid,
   output logic                                overrun
);

   localparam int LAST_LEN = K - (NUM_CHUNKS - 1) * MCA_NUM_ADDITIONS;

   seq_state_e state, state_n;
   logic       pending;
   logic       dly_valid;
   logic       last;
   logic       enter;
   logic       drop;
   logic [CW-1:0] idx_n;
   logic [LW-1:0] len_n;
   logic signed [WIDTH_COEFFICIENT-1:0] sum_sat;

   mca_sat_acc #(
      .W     (WIDTH_COEFFICIENT),
      .ACC_W (ACC_W)
   ) u_acc (
      .clk     (clk),
      .resetn  (resetn),
      .clr     (enter),
      .add_en  (dly_valid),
      .din     (partial_sum),
      .sum_sat (sum_sat)
   );

   assign busy = (state != IDLE);

   // Next state, chunk counter and start-queue decisions.
   always_comb begin
      state_n = state;
      last    = (chunk_idx == CW'(NUM_CHUNKS - 1));
      unique case (state)
         IDLE:    if (start || pending) state_n = ISSUE;
         ISSUE:   if (last) state_n = DRAIN;
         DRAIN:   state_n = (start || pending) ? ISSUE : IDLE;
         default: state_n = IDLE;
      endcase
      enter = (state_n == ISSUE) && (state != ISSUE);
      drop  = start && pending && (state != IDLE);
      idx_n = enter ? '0 : chunk_idx + CW'(1);
      len_n = (idx_n == CW'(NUM_CHUNKS - 1)) ?
              LW'(LAST_LEN) : LW'(MCA_NUM_ADDITIONS);
   end

   // State register, queue flag and registered outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         pending      <= 1'b0;
         dly_valid    <= 1'b0;
         chunk_idx    <= '0;
         chunk_len    <= '0;
         chunk_valid  <= 1'b0;
         sample       <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         state        <= state_n;
         dly_valid    <= chunk_valid;
         sample_valid <= (state == DRAIN);
         overrun      <= drop;
         if (state == ISSUE && start) pending <= 1'b1;
         else if (state != ISSUE) pending <= 1'b0;
         if (enter || (state == ISSUE && !last)) begin
            chunk_idx   <= idx_n;
            chunk_len   <= len_n;
            chunk_valid <= 1'b1;
         end else if (state == ISSUE) begin
            chunk_valid <= 1'b0;
         end
         if (state == DRAIN) sample <= sum_sat;
      end
   end

endmodule
